// File: rtl/iob2axi_rd.sv
// ---------------------------------------------------------------------------
// iob2axi_rd
//
// AXI-4 read-burst master that pulls one INCR burst of (length+1) beats
// starting at a byte address and streams the returned beats out on a
// native data port that has consumer backpressure. This is the read-side
// partner of the native-to-AXI write bridge.
//
// Operation:
//   - While idle, the start address and length are sampled every cycle, so
//     the values present when run is seen are the ones used for the burst.
//   - The AR request is presented until the slave accepts it; the request
//     fields come from registers and cannot move while arvalid is high.
//   - During the data phase the R channel is wired straight through to the
//     native port (zero latency): rready follows d_ready and d_valid follows
//     rvalid, so the consumer alone decides when a beat moves.
//   - The burst ends after exactly length+1 accepted beats, independent of
//     where the slave puts rlast.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   run               start a burst (honoured only while idle)
//   addr, length      burst start byte address, beat count minus one
//   ready             high while idle (previous burst finished)
//   error             sticky bad-response / rlast-mismatch flag of last burst
//   d_valid, d_addr,
//   d_rdata, d_ready  native beat output: valid, beat index, data, accept
//   m_axi_ar*         AXI read address channel (master side)
//   m_axi_r*          AXI read data channel (master side)
// ---------------------------------------------------------------------------
module iob2axi_rd #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int AXI_ADDR_W = ADDR_W,
    parameter int AXI_DATA_W = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,

    // Control
    input  logic                  run,
    input  logic [AXI_ADDR_W-1:0] addr,
    input  logic [7:0]            length,
    output logic                  ready,
    output logic                  error,

    // Native read data output
    output logic                  d_valid,
    output logic [ADDR_W-1:0]     d_addr,
    output logic [DATA_W-1:0]     d_rdata,
    input  logic                  d_ready,

    // AXI read address channel
    output logic                  m_axi_arid,
    output logic [AXI_ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [1:0]            m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    // AXI read data channel
    input  logic                  m_axi_rid,
    input  logic [AXI_DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;

    // Beat size code: bytes per beat expressed as log2
    localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_W / 8));

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [1:0]            state;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [7:0]            len_q;
    logic [8:0]            beat_cnt;
    logic                  error_q;

    // -----------------------------------------------------------------------
    // Derived handshake terms
    // -----------------------------------------------------------------------
    logic in_read;
    logic beat_accept;
    logic last_beat;
    logic beat_bad;

    assign in_read     = (state == ST_READ);
    assign beat_accept = in_read & m_axi_rvalid & d_ready;

    // The counter is one bit wider than length so a 256-beat burst still
    // compares cleanly against the 8-bit length.
    assign last_beat   = (beat_cnt == {1'b0, len_q});

    // A beat is flagged if the slave reports a non-OKAY response or places
    // rlast somewhere other than the beat we count as the last one.
    assign beat_bad    = (m_axi_rresp != 2'b00) | (m_axi_rlast != last_beat);

    // rid carries no information for a single-ID master.
    logic unused_rid;
    assign unused_rid = m_axi_rid;

    // -----------------------------------------------------------------------
    // Main FSM: idle -> address request -> data beats -> idle
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_arready) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    // An early rlast is deliberately ignored here; only the
                    // beat count decides when the burst is over.
                    if (beat_accept && last_beat) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Request capture: track the inputs while idle so the AR fields are
    // frozen from the cycle run is taken until the burst finishes.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
        end else if (state == ST_IDLE) begin
            addr_q <= addr;
            len_q  <= length;
        end
    end

    // -----------------------------------------------------------------------
    // Beat counter: index of the next beat to be handed to the consumer.
    // Cleared on the last beat so the next burst starts from zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (state == ST_IDLE) begin
            beat_cnt <= '0;
        end else if (beat_accept) begin
            if (last_beat) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 9'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sticky error: cleared when a new burst is launched, set by any bad
    // accepted beat, and otherwise held so software can read it after ready.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if (state == ST_IDLE && run) begin
            error_q <= 1'b0;
        end else if (beat_accept && beat_bad) begin
            error_q <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ready         = (state == ST_IDLE);
    assign error         = error_q;

    // AR channel: fields always come from the captured registers.
    assign m_axi_arid    = 1'b0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = AR_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 2'b00;
    assign m_axi_arcache = 4'b0010;
    assign m_axi_arprot  = 3'b010;
    assign m_axi_arqos   = 4'b0000;
    assign m_axi_arvalid = (state == ST_ADDR);

    // R channel to native port is a pure pass-through gated by the state, so
    // a beat offered during the address phase waits until the data phase.
    assign m_axi_rready  = in_read & d_ready;
    assign d_valid       = in_read & m_axi_rvalid;
    assign d_rdata       = DATA_W'(m_axi_rdata);
    assign d_addr        = ADDR_W'(beat_cnt);

endmodule

// File: tb/tb_iob2axi_rd.sv
// ---------------------------------------------------------------------------
// tb_iob2axi_rd
//
// Directed testbench for iob2axi_rd. A small in-bench AXI slave answers each
// burst with a known data pattern; the bench drives inputs just after the
// rising edge and samples outputs on the falling edge.
// ---------------------------------------------------------------------------
module tb_iob2axi_rd;

    logic        clk;
    logic        rst;
    logic        run;
    logic [31:0] addr;
    logic [7:0]  length;
    logic        ready;
    logic        error;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic [1:0]  m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic        m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int errors;
    int checks;

    iob2axi_rd dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .addr          (addr),
        .length        (length),
        .ready         (ready),
        .error         (error),
        .d_valid       (d_valid),
        .d_addr        (d_addr),
        .d_rdata       (d_rdata),
        .d_ready       (d_ready),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arqos   (m_axi_arqos),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Data the slave returns for a given burst address and beat index
    function automatic logic [31:0] beatData(input logic [31:0] a, input int beat);
        return a ^ (32'(beat) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    // Move to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Run one complete burst against the in-bench slave.
    //   ar_wait   : cycles arready stays low before the handshake
    //   toggle    : d_ready follows 1,0,1,0... instead of staying high
    //   bad_beat  : beat returned with SLVERR (-1 for none)
    //   last_at   : beat carrying rlast (len for a well-behaved slave)
    //   rst_beat  : assert reset while this beat is offered (-1 for none)
    task automatic applyStimulus(input logic [31:0] a, input logic [7:0] len, input int ar_wait,
                                 input bit toggle, input int bad_beat, input int last_at,
                                 input int rst_beat);
        int  beat;
        int  cyc;
        logic exp_err;
        exp_err = (bad_beat >= 0) || (last_at != int'(len));

        // Idle cycle: present the request
        run    = 1'b1;
        addr   = a;
        length = len;
        @(negedge clk);
        checkOutput("idle_ready", ready, 1);
        checkOutput("idle_arvalid", m_axi_arvalid, 0);
        nextCycle();

        // Address phase: scramble the request inputs and keep run high; the
        // latched AR fields must not follow. Beat 0 is already on offer.
        addr         = ~a;
        length       = ~len;
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = beatData(a, 0);
        m_axi_rresp  = 2'b00;
        m_axi_rlast  = (last_at == 0);
        d_ready      = 1'b1;
        for (int c = 0; c <= ar_wait; c++) begin
            m_axi_arready = (c == ar_wait);
            @(negedge clk);
            checkOutput("addr_arvalid", m_axi_arvalid, 1);
            checkOutput("addr_araddr", m_axi_araddr, a);
            checkOutput("addr_arlen", m_axi_arlen, len);
            checkOutput("addr_rready", m_axi_rready, 0);
            checkOutput("addr_dvalid", d_valid, 0);
            checkOutput("addr_ready", ready, 0);
            checkOutput("addr_error_cleared", error, 0);
            if (c == 0) begin
                checkOutput("arsize", m_axi_arsize, 2);
                checkOutput("arburst", m_axi_arburst, 1);
                checkOutput("arid", m_axi_arid, 0);
                checkOutput("arlock", m_axi_arlock, 0);
                checkOutput("arcache", m_axi_arcache, 2);
                checkOutput("arprot", m_axi_arprot, 2);
                checkOutput("arqos", m_axi_arqos, 0);
            end
            nextCycle();
        end
        m_axi_arready = 1'b0;
        run           = 1'b0;

        // Data phase
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 1000) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = beatData(a, beat);
            m_axi_rresp  = (beat == bad_beat) ? 2'b10 : 2'b00;
            m_axi_rlast  = (beat == last_at);
            d_ready      = toggle ? (cyc % 2 == 0) : 1'b1;
            if (beat == rst_beat) begin
                rst = 1'b1;
                @(negedge clk);
                checkOutput("rst_ready", ready, 1);
                checkOutput("rst_arvalid", m_axi_arvalid, 0);
                checkOutput("rst_rready", m_axi_rready, 0);
                checkOutput("rst_dvalid", d_valid, 0);
                checkOutput("rst_error", error, 0);
                checkOutput("rst_araddr", m_axi_araddr, 0);
                nextCycle();
                rst          = 1'b0;
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                d_ready      = 1'b1;
                return;
            end
            @(negedge clk);
            checkOutput("read_dvalid", d_valid, 1);
            checkOutput("read_rready", m_axi_rready, d_ready);
            checkOutput("read_daddr", d_addr, 64'(beat));
            checkOutput("read_drdata", d_rdata, beatData(a, beat));
            checkOutput("read_arvalid", m_axi_arvalid, 0);
            checkOutput("read_ready", ready, 0);
            nextCycle();
            if (d_ready) beat++;
            cyc++;
        end
        if (beat <= int'(len)) begin
            checkOutput("read_timeout_beats", 64'(beat), 64'(int'(len) + 1));
        end

        // One cycle after the last beat: back to idle. rvalid is left high
        // to confirm it cannot leak through outside the data phase.
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        d_ready      = 1'b1;
        @(negedge clk);
        checkOutput("done_ready", ready, 1);
        checkOutput("done_error", error, exp_err);
        checkOutput("done_dvalid", d_valid, 0);
        checkOutput("done_rready", m_axi_rready, 0);
        checkOutput("done_arvalid", m_axi_arvalid, 0);
        nextCycle();
        m_axi_rvalid = 1'b0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        run           = 1'b0;
        addr          = 32'h0;
        length        = 8'h0;
        d_ready       = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rid     = 1'b0;
        m_axi_rdata   = 32'h0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b0;

        // Reset state, with rvalid/d_ready high to show they are masked
        m_axi_rvalid = 1'b1;
        d_ready      = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", ready, 1);
        checkOutput("reset_error", error, 0);
        checkOutput("reset_arvalid", m_axi_arvalid, 0);
        checkOutput("reset_rready", m_axi_rready, 0);
        checkOutput("reset_dvalid", d_valid, 0);
        checkOutput("reset_araddr", m_axi_araddr, 0);
        checkOutput("reset_arlen", m_axi_arlen, 0);
        nextCycle();
        nextCycle();
        rst          = 1'b0;
        m_axi_rvalid = 1'b0;
        nextCycle();

        $display("[TB] burst 4 beats at 0x100");
        applyStimulus(32'h0000_0100, 8'd3, 0, 1'b0, -1, 3, -1);

        $display("[TB] single beat burst");
        applyStimulus(32'h0000_2000, 8'd0, 0, 1'b0, -1, 0, -1);

        $display("[TB] arready delayed 5 cycles");
        applyStimulus(32'h0000_3040, 8'd2, 5, 1'b0, -1, 2, -1);

        $display("[TB] 8 beats with toggling d_ready");
        applyStimulus(32'h1234_5600, 8'd7, 1, 1'b1, -1, 7, -1);

        $display("[TB] SLVERR on beat 2, then clean burst");
        applyStimulus(32'h0000_4000, 8'd3, 0, 1'b0, 2, 3, -1);
        applyStimulus(32'h0000_5000, 8'd1, 0, 1'b0, -1, 1, -1);

        $display("[TB] early rlast does not end the burst");
        applyStimulus(32'h0000_6000, 8'd2, 0, 1'b0, -1, 0, -1);

        $display("[TB] reset during beat 1, then normal burst");
        applyStimulus(32'h0000_7000, 8'd3, 0, 1'b0, -1, 3, 1);
        nextCycle();
        applyStimulus(32'h0000_8000, 8'd1, 0, 1'b0, -1, 1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iob2axi_rd.md
Name: iob2axi_rd

Overview:
- AXI-4 Full read-burst master; read-side counterpart of the native-to-AXI write bridge.
- On `run`, issues one INCR read burst of `length+1` beats at `addr`.
- Streams returned beats out on a native master data port with backpressure.
- Reports completion on `ready` and bad responses on `error`. Sits between the AXI interconnect and a native consumer (DMA, buffer).

Parameters:
- ADDR_W, 32, native data-port address width (beat index output).
- DATA_W, 32, native data width; equals AXI data width.
- AXI_ADDR_W, ADDR_W, AXI address width.
- AXI_DATA_W, DATA_W, AXI data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- run  in  1  start burst (sampled only while idle)
- addr  in  AXI_ADDR_W  burst start byte address
- length  in  8  beats minus one
- ready  out  1  idle / previous burst complete
- error  out  1  sticky error of last burst
- d_valid  out  1  read beat valid
- d_addr  out  ADDR_W  beat index within burst, 0..length
- d_rdata  out  DATA_W  beat data
- d_ready  in  1  consumer accepts beat
- m_axi_arid  out  1  constant 0
- m_axi_araddr  out  AXI_ADDR_W  latched addr
- m_axi_arlen  out  8  latched length
- m_axi_arsize  out  3  clog2(DATA_W/8)
- m_axi_arburst  out  2  constant 1 (INCR)
- m_axi_arlock/arcache/arprot/arqos  out  2/4/3/4  constants 0/2/2/0
- m_axi_arvalid  out  1  address valid
- m_axi_arready  in  1  address ready
- m_axi_rid  in  1  ignored
- m_axi_rdata  in  AXI_DATA_W  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat
- m_axi_rvalid  in  1  data valid
- m_axi_rready  out  1  data ready

Behaviour:
- Reset values: state IDLE, `ready`=1, `error`=0, `m_axi_arvalid`=0, `m_axi_rready`=0, `d_valid`=0, beat counter 0, latched addr/length 0.
- States:
  - IDLE: `ready`=1; `addr`/`length` latched every cycle. If `run`=1: clear `error`, set `ready`=0 on the next cycle, go to ADDR.
  - ADDR: `arvalid`=1, held until `arready` sampled high, then go to READ. AR fields stay stable while `arvalid` is high.
  - READ: `m_axi_rready`=`d_ready`; `d_valid`=`m_axi_rvalid`; `d_rdata`=`m_axi_rdata` (combinational, zero latency); `d_addr`=counter.
- Beat accept: `rvalid` & `rready`. On accept, counter increments (9-bit internally).
- Burst end: on accept with counter==length, go to IDLE; `ready`=1 the following cycle and counter is cleared.
- Error flag: set if any accepted beat has `rresp`!=0, or if `rlast` disagrees with counter==length on an accepted beat. Remains set until the next `run` is accepted.
- An early `rlast` does not end the burst; the block waits for `length+1` beats.
- Outside READ: `d_valid`=0 and `rready`=0 regardless of `rvalid`.
- `run` asserted outside IDLE is ignored.
- `length`=0: single beat; `rlast` is expected on beat 0.
- Simultaneous `arready` and first `rvalid` in the same ADDR cycle: the beat is not accepted until READ (`rready`=0 in ADDR).
- `rst` mid-burst: immediately IDLE with reset values. AXI protocol recovery is the system's responsibility.
- Minimum turnaround: run → arvalid 1 cycle; last beat → `ready` 1 cycle.

Test Plan:
- `addr`=0x100, `length`=3, `arready` immediate, `rvalid` every cycle, `rresp`=0, `d_ready`=1 → `arlen`=3, `arsize`=2, four beats with `d_addr` 0..3, `ready` returns 1 cycle after beat 3, `error`=0.
- `length`=0, `rlast` on beat 0 → exactly one `d_valid` beat, `error`=0.
- `arready` delayed 5 cycles → `arvalid` held 5 cycles with `araddr`/`arlen` stable; no `rready` before handshake.
- `length`=7, `d_ready` toggling 1010…, `rvalid`=1 → `rready` mirrors `d_ready`; 8 beats delivered in order; data matches pattern.
- Beat 2 of 4 returns `rresp`=2 → `error`=1 after completion; cleared on next `run`, and a clean burst leaves it 0.
- Assert `rst` during beat 1 of 4 → next cycle `ready`=1, `arvalid`=0, `rready`=0; a following run with `length`=1 completes normally.
